// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operand stage: default widths,
// ALU/branch opcode encodings and the operand-select enums.
package alu_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int REG_IDX_W_DEF = 5;
    localparam int NUM_FWD_DEF   = 2;
    localparam int ALUOP_W_DEF   = 4;
    localparam int BROP_W_DEF    = 3;
    localparam int PERF_W_DEF    = 16;

    // ALU opcodes
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_SLT  = 8;
    localparam int ALU_SLTU = 9;

    // Branch opcodes; BR_NONE marks a non-branch instruction
    localparam int BR_NONE = 0;
    localparam int BR_BEQ  = 1;
    localparam int BR_BNE  = 2;
    localparam int BR_BLT  = 3;
    localparam int BR_BGE  = 4;
    localparam int BR_BLTU = 5;
    localparam int BR_BGEU = 6;
    localparam int BR_JAL  = 7;

    // Source of ALU operand 1: forwarded rs1 or the next PC (branches)
    typedef enum logic {
        SRC1_REG = 1'b0,
        SRC1_NPC = 1'b1
    } src1_sel_e;

    // Source of ALU operand 2: forwarded rs2 or the immediate
    typedef enum logic {
        SRC2_REG = 1'b0,
        SRC2_IMM = 1'b1
    } src2_sel_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-to-ALU bus of the operand stage: the decode-side valid/ready
// transfer and the ALU-side valid/ready transfer. The stage is the slave.
interface alu_operand_stage_if
    import alu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int ALUOP_W   = ALUOP_W_DEF,
    parameter int BROP_W    = BROP_W_DEF
) ();

    // decode side
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_a;
    logic [XLEN-1:0]      in_b;
    logic [XLEN-1:0]      in_imm;
    logic [XLEN-1:0]      in_npc;
    logic [REG_IDX_W-1:0] in_rs1;
    logic [REG_IDX_W-1:0] in_rs2;
    logic                 in_use_rs1;
    logic                 in_use_rs2;
    logic [BROP_W-1:0]    in_branch_op;
    logic                 in_alu_src;
    logic [ALUOP_W-1:0]   in_alu_op;

    // ALU side
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_alu_in1;
    logic [XLEN-1:0]      out_alu_in2;
    logic [XLEN-1:0]      out_store_data;
    logic [ALUOP_W-1:0]   out_alu_op;
    logic [BROP_W-1:0]    out_branch_op;

    modport master (
        output in_valid, in_a, in_b, in_imm, in_npc, in_rs1, in_rs2,
               in_use_rs1, in_use_rs2, in_branch_op, in_alu_src, in_alu_op,
               out_ready,
        input  in_ready,
               out_valid, out_alu_in1, out_alu_in2, out_store_data,
               out_alu_op, out_branch_op
    );

    modport slave (
        input  in_valid, in_a, in_b, in_imm, in_npc, in_rs1, in_rs2,
               in_use_rs1, in_use_rs2, in_branch_op, in_alu_src, in_alu_op,
               out_ready,
        output in_ready,
               out_valid, out_alu_in1, out_alu_in2, out_store_data,
               out_alu_op, out_branch_op
    );

endinterface

// File: rtl/alu_operand_stage_fwd_select.sv
// Priority forwarding mux for one source register. The youngest in-flight
// producer (lowest index) writing the register wins; register 0 and unused
// sources never forward. 'pending' reports whether the winner is not ready.
module fwd_select
    import alu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int NUM_FWD   = NUM_FWD_DEF
) (
    input  logic [REG_IDX_W-1:0]         idx,
    input  logic                         use_src,
    input  logic [XLEN-1:0]              rf_val,
    input  logic [NUM_FWD-1:0]           fwd_valid,
    input  logic [NUM_FWD-1:0]           fwd_pending,
    input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]      fwd_data,
    output logic [XLEN-1:0]              value,
    output logic                         pending
);

    // Scan oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        // NOTE: outputs get defaults before the scan so every path assigns them and no latch is inferred.
        value   = rf_val;
        pending = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (use_src && (idx != '0) && fwd_valid[i] &&
                (fwd_rd[i*REG_IDX_W +: REG_IDX_W] == idx)) begin
                value   = fwd_data[i*XLEN +: XLEN];
                pending = fwd_pending[i];
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ID/EX operand stage: resolves ALU operands from register-file
// data, forwarding sources, immediate and next PC, with load-use stall,
// valid/ready handshake on both sides and flush.
// Optional stall counter: define ALU_OPERAND_PERF_EN to add the stall_cnt port.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int NUM_FWD   = NUM_FWD_DEF,
    parameter int ALUOP_W   = ALUOP_W_DEF,
    parameter int BROP_W    = BROP_W_DEF
`ifdef ALU_OPERAND_PERF_EN
    ,
    parameter int PERF_W    = PERF_W_DEF
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    alu_operand_stage_if.slave           bus,
    input  logic [NUM_FWD-1:0]           fwd_valid,
    input  logic [NUM_FWD-1:0]           fwd_pending,
    input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]      fwd_data
`ifdef ALU_OPERAND_PERF_EN
    ,
    output logic [PERF_W-1:0]            stall_cnt
`endif
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            pend_a;
    logic            pend_b;
    logic            hazard;
    logic            in_ready;
    logic            capture;
    src1_sel_e       src1_sel;
    src2_sel_e       src2_sel;

    logic               valid_q,   valid_d;
    logic [XLEN-1:0]    alu_in1_q, alu_in1_d;
    logic [XLEN-1:0]    alu_in2_q, alu_in2_d;
    logic [XLEN-1:0]    store_q,   store_d;
    logic [ALUOP_W-1:0] alu_op_q,  alu_op_d;
    logic [BROP_W-1:0]  br_op_q,   br_op_d;

    fwd_select #(
        .XLEN      (XLEN),
        .REG_IDX_W (REG_IDX_W),
        .NUM_FWD   (NUM_FWD)
    ) u_fwd_rs1 (
        .idx         (bus.in_rs1),
        .use_src     (bus.in_use_rs1),
        .rf_val      (bus.in_a),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .value       (op_a),
        .pending     (pend_a)
    );

    fwd_select #(
        .XLEN      (XLEN),
        .REG_IDX_W (REG_IDX_W),
        .NUM_FWD   (NUM_FWD)
    ) u_fwd_rs2 (
        .idx         (bus.in_rs2),
        .use_src     (bus.in_use_rs2),
        .rf_val      (bus.in_b),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .value       (op_b),
        .pending     (pend_b)
    );

    // Load-use hazard, handshake and operand-source selection
    always_comb begin
        hazard   = pend_a | pend_b;
        in_ready = !flush && !hazard && (!valid_q || bus.out_ready);
        capture  = bus.in_valid && in_ready;
        src1_sel = (bus.in_branch_op == BROP_W'(BR_NONE)) ? SRC1_REG : SRC1_NPC;
        src2_sel = bus.in_alu_src ? SRC2_IMM : SRC2_REG;
    end

    // Next state of the output entry: flush, then capture, then drain, else hold
    always_comb begin
        valid_d   = valid_q;
        alu_in1_d = alu_in1_q;
        alu_in2_d = alu_in2_q;
        store_d   = store_q;
        alu_op_d  = alu_op_q;
        br_op_d   = br_op_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d   = 1'b1;
            alu_in1_d = (src1_sel == SRC1_NPC) ? bus.in_npc : op_a;
            alu_in2_d = (src2_sel == SRC2_IMM) ? bus.in_imm : op_b;
            store_d   = op_b;
            alu_op_d  = bus.in_alu_op;
            br_op_d   = bus.in_branch_op;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output entry registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments; the datapath registers are reset as well so nothing from before reset is ever presented.
        if (!rst_n) begin
            valid_q   <= 1'b0;
            alu_in1_q <= '0;
            alu_in2_q <= '0;
            store_q   <= '0;
            alu_op_q  <= '0;
            br_op_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            alu_in1_q <= alu_in1_d;
            alu_in2_q <= alu_in2_d;
            store_q   <= store_d;
            alu_op_q  <= alu_op_d;
            br_op_q   <= br_op_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = valid_q;
    assign bus.out_alu_in1    = alu_in1_q;
    assign bus.out_alu_in2    = alu_in2_q;
    assign bus.out_store_data = store_q;
    assign bus.out_alu_op     = alu_op_q;
    assign bus.out_branch_op  = br_op_q;

`ifdef ALU_OPERAND_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles an instruction waits on a load-use hazard
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.in_valid && hazard && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios followed by
// randomized traffic, checked by a scoreboard fed from a behavioural model.
module tb_alu_operand_stage;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_FWD   = 2;
    localparam int ALUOP_W   = 4;
    localparam int BROP_W    = 3;
`ifdef ALU_OPERAND_PERF_EN
    localparam int PERF_W    = 16;
`endif

    typedef struct {
        logic [XLEN-1:0]    in1;
        logic [XLEN-1:0]    in2;
        logic [XLEN-1:0]    sd;
        logic [ALUOP_W-1:0] op;
        logic [BROP_W-1:0]  br;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush;

    logic                 fv    [NUM_FWD];
    logic                 fpend [NUM_FWD];
    logic [REG_IDX_W-1:0] frd   [NUM_FWD];
    logic [XLEN-1:0]      fdata [NUM_FWD];

    logic [NUM_FWD-1:0]           fwd_valid;
    logic [NUM_FWD-1:0]           fwd_pending;
    logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd;
    logic [NUM_FWD*XLEN-1:0]      fwd_data;
`ifdef ALU_OPERAND_PERF_EN
    logic [PERF_W-1:0]            stall_cnt;
    int unsigned                  m_stall;
`endif

    exp_t sb[$];
    logic m_valid;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM_FWD; g++) begin : g_pack
        assign fwd_valid[g]                        = fv[g];
        assign fwd_pending[g]                      = fpend[g];
        assign fwd_rd[g*REG_IDX_W +: REG_IDX_W]    = frd[g];
        assign fwd_data[g*XLEN +: XLEN]            = fdata[g];
    end

    alu_operand_stage_if #(
        .XLEN(XLEN), .REG_IDX_W(REG_IDX_W), .ALUOP_W(ALUOP_W), .BROP_W(BROP_W)
    ) bus ();

    alu_operand_stage #(
        .XLEN(XLEN), .REG_IDX_W(REG_IDX_W), .NUM_FWD(NUM_FWD),
        .ALUOP_W(ALUOP_W), .BROP_W(BROP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
`ifdef ALU_OPERAND_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value seen by one source: the youngest in-flight writer of that register,
    // otherwise the register-file value; register 0 never forwards.
    task automatic resolve(input logic [REG_IDX_W-1:0] idx, input logic used,
                           input logic [XLEN-1:0] rf,
                           output logic [XLEN-1:0] val, output logic pend);
        val  = rf;
        pend = 1'b0;
        if (used && idx != 0) begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (fv[i] && frd[i] == idx) begin
                    val  = fdata[i];
                    pend = fpend[i];
                    break;
                end
            end
        end
    endtask

    task automatic model_step();
        logic [XLEN-1:0] opa, opb;
        logic            pa, pb, haz, exp_ready;
        exp_t            e;
        resolve(bus.in_rs1, bus.in_use_rs1, bus.in_a, opa, pa);
        resolve(bus.in_rs2, bus.in_use_rs2, bus.in_b, opb, pb);
        haz       = pa || pb;
        exp_ready = !flush && !haz && (!m_valid || bus.out_ready);
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
`ifdef ALU_OPERAND_PERF_EN
        check("stall_cnt", 32'(stall_cnt), m_stall);
        if (bus.in_valid && haz && !flush && m_stall < 32'hFFFF) m_stall++;
`endif
        if (flush) begin
            m_valid = 1'b0;
            sb.delete();
        end else if (bus.in_valid && exp_ready) begin
            e.in1 = (bus.in_branch_op == 0) ? opa : bus.in_npc;
            e.in2 = bus.in_alu_src ? bus.in_imm : opb;
            e.sd  = opb;
            e.op  = bus.in_alu_op;
            e.br  = bus.in_branch_op;
            sb.push_back(e);
            m_valid = 1'b1;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Model: inputs are driven just after posedge, so they are stable here
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) model_step();
        end
    end

    // Monitor: whenever operands are presented they must match the oldest expected entry
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check("alu_in1",    bus.out_alu_in1,          sb[0].in1);
                    check("alu_in2",    bus.out_alu_in2,          sb[0].in2);
                    check("store_data", bus.out_store_data,       sb[0].sd);
                    check("alu_op",     32'(bus.out_alu_op),      32'(sb[0].op));
                    check("branch_op",  32'(bus.out_branch_op),   32'(sb[0].br));
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        flush            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_a         = '0;
        bus.in_b         = '0;
        bus.in_imm       = '0;
        bus.in_npc       = '0;
        bus.in_rs1       = '0;
        bus.in_rs2       = '0;
        bus.in_use_rs1   = 1'b0;
        bus.in_use_rs2   = 1'b0;
        bus.in_branch_op = '0;
        bus.in_alu_src   = 1'b0;
        bus.in_alu_op    = '0;
        bus.out_ready    = 1'b1;
        for (int i = 0; i < NUM_FWD; i++) begin
            fv[i] = 1'b0; fpend[i] = 1'b0; frd[i] = '0; fdata[i] = '0;
        end
    endtask

    task automatic set_random();
        flush            = ($urandom_range(0, 24) == 0);
        bus.in_valid     = ($urandom_range(0, 3) != 0);
        bus.in_a         = $urandom;
        bus.in_b         = $urandom;
        bus.in_imm       = $urandom;
        bus.in_npc       = $urandom;
        bus.in_rs1       = REG_IDX_W'($urandom_range(0, 4));
        bus.in_rs2       = REG_IDX_W'($urandom_range(0, 4));
        bus.in_use_rs1   = ($urandom_range(0, 3) != 0);
        bus.in_use_rs2   = ($urandom_range(0, 3) != 0);
        bus.in_branch_op = ($urandom_range(0, 3) == 0) ? BROP_W'($urandom) : '0;
        bus.in_alu_src   = $urandom_range(0, 1) == 1;
        bus.in_alu_op    = ALUOP_W'($urandom);
        bus.out_ready    = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < NUM_FWD; i++) begin
            fv[i]    = ($urandom_range(0, 2) != 0);
            fpend[i] = ($urandom_range(0, 4) == 0);
            frd[i]   = REG_IDX_W'($urandom_range(0, 4));
            fdata[i] = $urandom;
        end
    endtask

    // Asynchronous reset while an entry is held: everything clears at once
    task automatic mid_reset();
        rst_n   = 1'b0;
        m_valid = 1'b0;
        sb.delete();
`ifdef ALU_OPERAND_PERF_EN
        m_stall = 0;
`endif
        #2;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_alu_in1",   bus.out_alu_in1,        32'd0);
        check("rst_alu_in2",   bus.out_alu_in2,        32'd0);
        check("rst_store",     bus.out_store_data,     32'd0);
        check("rst_alu_op",    32'(bus.out_alu_op),    32'd0);
        check("rst_branch_op", 32'(bus.out_branch_op), 32'd0);
`ifdef ALU_OPERAND_PERF_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        set_idle();
        m_valid = 1'b0;
`ifdef ALU_OPERAND_PERF_EN
        m_stall = 0;
`endif
        step();
        mid_reset();

        // 1: plain register operands
        bus.in_valid = 1'b1; bus.in_a = 32'd5; bus.in_b = 32'd7;
        bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd2; bus.in_use_rs1 = 1'b1; bus.in_use_rs2 = 1'b1;
        bus.in_alu_op = 4'd0;
        step();
        set_idle();
        step();

        // 2: youngest forwarding source wins
        bus.in_valid = 1'b1; bus.in_rs1 = 5'd3; bus.in_use_rs1 = 1'b1; bus.in_a = 32'h1;
        fv[0] = 1'b1; frd[0] = 5'd3; fdata[0] = 32'hAA;
        fv[1] = 1'b1; frd[1] = 5'd3; fdata[1] = 32'hBB;
        step();
        set_idle();
        step();

        // 3: load-use stall for three cycles, then forward the loaded value
        bus.in_valid = 1'b1; bus.in_rs2 = 5'd4; bus.in_use_rs2 = 1'b1; bus.in_b = 32'h99;
        fv[0] = 1'b1; frd[0] = 5'd4; fpend[0] = 1'b1; fdata[0] = 32'h0;
        fv[1] = 1'b1; frd[1] = 5'd4; fpend[1] = 1'b0; fdata[1] = 32'h77;
        repeat (3) step();
        fpend[0] = 1'b0; fdata[0] = 32'h10;
        step();
        set_idle();
        step();

        // older pending entry shadowed by a younger ready one: no stall
        bus.in_valid = 1'b1; bus.in_rs1 = 5'd2; bus.in_use_rs1 = 1'b1;
        fv[0] = 1'b1; frd[0] = 5'd2; fdata[0] = 32'h33;
        fv[1] = 1'b1; frd[1] = 5'd2; fpend[1] = 1'b1;
        step();
        set_idle();
        step();

        // 4: backpressure for three cycles with new requests waiting
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 32'h1111; bus.in_b = 32'h2222; bus.in_alu_op = 4'd3;
        step();
        bus.in_a = 32'h3333; bus.in_b = 32'h4444; bus.in_alu_op = 4'd5;
        repeat (3) step();
        bus.out_ready = 1'b1;
        step();
        set_idle();
        step();

        // 5: branch takes NPC, immediate on operand 2; register 0 never forwards
        bus.in_valid = 1'b1; bus.in_branch_op = 3'd2; bus.in_npc = 32'h104;
        bus.in_alu_src = 1'b1; bus.in_imm = 32'd8;
        bus.in_rs1 = 5'd0; bus.in_use_rs1 = 1'b1; bus.in_a = 32'h55;
        bus.in_rs2 = 5'd0; bus.in_use_rs2 = 1'b1; bus.in_b = 32'h66;
        fv[0] = 1'b1; frd[0] = 5'd0; fdata[0] = 32'hDEAD;
        step();
        bus.in_branch_op = 3'd0; bus.in_alu_src = 1'b0;
        step();
        set_idle();
        step();

        // 6: flush with an entry held and a new request present
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 32'hABCD;
        step();
        flush = 1'b1; bus.in_a = 32'hEF01;
        step();
        set_idle();
        step();

        // reset while an entry is held
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 32'h5A5A;
        step();
        set_idle();
        bus.out_ready = 1'b0;
        mid_reset();
        set_idle();
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set_random();
            step();
        end

        set_idle();
        repeat (4) step();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
